// File: rtl/fod_pkg.sv
// Shared FCW types, widths and range limits for the FOD feeder blocks.
package fod_pkg;

  localparam int WI    = 6;
  localparam int WF    = 16;
  localparam int FCW_W = WI + WF;
  localparam int DW_W  = 8;

  typedef logic [FCW_W-1:0] fcw_t;
  typedef logic [DW_W-1:0]  dwell_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } ramp_st_t;

  localparam fcw_t FCW_INIT = fcw_t'(4 << WF);
  localparam fcw_t FCW_MIN  = fcw_t'(2 << WF);
  localparam fcw_t FCW_MAX  = fcw_t'(((1 << WI) - 1) << WF);

  // Saturate an FCW word into [lo, hi].
  function automatic fcw_t clamp_fcw(input fcw_t v, input fcw_t lo, input fcw_t hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/fod_fcw_ramp_if.sv
// Target handshake, ramp controls and FCW status between an upstream
// controller (master) and the ramp generator (slave).
//
// Handshake: a target transfers on a rising CLK edge where TGT_VLD and
// TGT_RDY are both 1. TGT_RDY is a registered output that is 1 only
// while the ramp generator is idle; the master holds TGT_FCW stable while
// TGT_VLD is 1 and may drop TGT_VLD after the transfer edge.
interface fod_fcw_ramp_if;
  import fod_pkg::*;

  fcw_t     TGT_FCW;
  logic     TGT_VLD;
  logic     TGT_RDY;
  fcw_t     RAMP_STEP;
  dwell_t   RAMP_DWELL;
  logic     FREEZE;
  fcw_t     FCW_FOD;
  logic     RAMP_BUSY;
  logic     RAMP_DONE;
  logic     RANGE_ERR;
  ramp_st_t dbg_state;

  modport master (
    output TGT_FCW, TGT_VLD, RAMP_STEP, RAMP_DWELL, FREEZE,
    input  TGT_RDY, FCW_FOD, RAMP_BUSY, RAMP_DONE, RANGE_ERR, dbg_state
  );

  modport slave (
    input  TGT_FCW, TGT_VLD, RAMP_STEP, RAMP_DWELL, FREEZE,
    output TGT_RDY, FCW_FOD, RAMP_BUSY, RAMP_DONE, RANGE_ERR, dbg_state
  );

endinterface

// File: rtl/fod_fcw_step.sv
// Combinational single ramp step: clamp the target, compare it with the
// current FCW and move one step toward it without overshooting.
module fod_fcw_step
  import fod_pkg::*;
#(
  parameter fcw_t MIN_FCW = FCW_MIN,
  parameter fcw_t MAX_FCW = FCW_MAX
) (
  input  fcw_t cur,
  input  fcw_t tgt,
  input  fcw_t step,
  output fcw_t nxt,
  output logic hit
);

  fcw_t             tgt_c;
  fcw_t             step_eff;
  logic [FCW_W:0]   diff;
  logic [FCW_W:0]   mag;
  logic             neg;

  // Zero step is treated as one LSB so a ramp always makes progress; the
  // difference carries one extra bit so its sign is never lost.
  always_comb begin
    tgt_c    = clamp_fcw(tgt, MIN_FCW, MAX_FCW);
    step_eff = (step == '0) ? fcw_t'(1) : step;
    diff     = {1'b0, tgt_c} - {1'b0, cur};
    neg      = diff[FCW_W];
    mag      = neg ? (~diff + 1'b1) : diff;
    hit      = (mag <= {1'b0, step_eff});
    if (hit) begin
      nxt = tgt_c;
    end else if (neg) begin
      nxt = cur - step_eff;
    end else begin
      nxt = cur + step_eff;
    end
  end

endmodule

// File: rtl/fod_fcw_ramp.sv
// FCW ramp generator feeding FOD_CTRL: accepts a target, clamps it to the
// legal MMD/DTC range and slews FCW_FOD toward it in bounded steps.
module fod_fcw_ramp
  import fod_pkg::*;
#(
  parameter fcw_t INIT_FCW = FCW_INIT,
  parameter fcw_t MIN_FCW  = FCW_MIN,
  parameter fcw_t MAX_FCW  = FCW_MAX
) (
  input logic           CLK,
  input logic           NARST,
  fod_fcw_ramp_if.slave bus
);

  ramp_st_t state_q, state_d;
  fcw_t     fcw_q, fcw_d;
  fcw_t     tgt_q, tgt_d;
  dwell_t   cnt_q, cnt_d;
  logic     rdy_q, rdy_d;
  logic     busy_q, busy_d;
  logic     done_q, done_d;
  logic     err_q, err_d;

  fcw_t     tgt_clamped;
  dwell_t   dwell_last;
  fcw_t     step_nxt;
  logic     step_hit;

  fod_fcw_step #(
    .MIN_FCW (MIN_FCW),
    .MAX_FCW (MAX_FCW)
  ) u_step (
    .cur  (fcw_q),
    .tgt  (tgt_q),
    .step (bus.RAMP_STEP),
    .nxt  (step_nxt),
    .hit  (step_hit)
  );

  // Clamp the incoming target and find the last count of a dwell period
  // (a zero dwell behaves as one cycle).
  always_comb begin
    tgt_clamped = clamp_fcw(bus.TGT_FCW, MIN_FCW, MAX_FCW);
    dwell_last  = (bus.RAMP_DWELL == '0) ? '0 : (bus.RAMP_DWELL - 1'b1);
  end

  // Next-state logic; status outputs are derived from the next state so
  // they are registered alongside it.
  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.TGT_VLD && rdy_q) begin
          tgt_d   = tgt_clamped;
          err_d   = (tgt_clamped != bus.TGT_FCW);
          cnt_d   = '0;
          state_d = (tgt_clamped != fcw_q) ? RAMP : DONE;
        end
      end
      RAMP: begin
        if (!bus.FREEZE) begin
          if (cnt_q == dwell_last) begin
            cnt_d = '0;
            fcw_d = step_nxt;
            if (step_hit) begin
              state_d = DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d == RAMP);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset; reset
  // abandons any ramp and holds TGT_RDY low for the reset cycle.
  always_ff @(posedge CLK) begin
    if (!NARST) begin
      state_q <= IDLE;
      fcw_q   <= INIT_FCW;
      tgt_q   <= INIT_FCW;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcw_q   <= fcw_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.TGT_RDY   = rdy_q;
  assign bus.FCW_FOD   = fcw_q;
  assign bus.RAMP_BUSY = busy_q;
  assign bus.RAMP_DONE = done_q;
  assign bus.RANGE_ERR = err_q;
  assign bus.dbg_state = state_q;

endmodule
